// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two-requester arbiter/sequencer for one shared multi-cycle ALU
// Round-robin by default; define ALU_ARB_FIXED_PRIORITY_EN for fixed priority (requester 0 wins ties).
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [5:0]              req_alu_op,
    input  logic [11:0]             req_func,
    input  logic [2*DATA_WIDTH-1:0] req_a,
    input  logic [2*DATA_WIDTH-1:0] req_b,
    output logic [2:0]              alu_op,
    output logic [5:0]              alu_function,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    input  logic [DATA_WIDTH-1:0]   alu_result,
    input  logic                    alu_zero,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_result,
    output logic                    rsp_zero,
    output logic                    busy
);
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("alu_share_arbiter: LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic       owner;
    logic       grant;
    logic       accept;

`ifdef ALU_ARB_FIXED_PRIORITY_EN
    assign grant = ~req_valid[0];
`else
    logic last_grant;
    // on a tie the requester that did not win last time goes first
    assign grant = &req_valid ? ~last_grant : req_valid[1];
    always_ff @(posedge clk or posedge reset)
        if (reset)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant;
`endif

    assign accept    = state == IDLE && |req_valid;
    assign req_ready = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = state == RESP ? (owner ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = accept                                ? EXEC :
                   (state == EXEC && cnt == 3'd1)        ? RESP :
                   (state == RESP && rsp_ready[owner])   ? IDLE : state;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            owner        <= 1'b0;
            cnt          <= 3'd0;
            alu_op       <= 3'd0;
            alu_function <= 6'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
        end else begin
            if (accept) begin
                owner        <= grant;
                cnt          <= 3'(LATENCY);
                alu_op       <= grant ? req_alu_op[5:3] : req_alu_op[2:0];
                alu_function <= grant ? req_func[11:6] : req_func[5:0];
                alu_a        <= grant ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
                alu_b        <= grant ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
            end
            if (state == EXEC) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1) begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                end
            end
        end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: scoreboard bench driving a LATENCY=1 and a LATENCY=3 instance
module tb_alu_share_arbiter;
`ifdef ALU_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef struct packed {
        logic        owner;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  rv [2];
    logic [1:0]  rr [2];
    logic [5:0]  op [2];
    logic [11:0] fn [2];
    logic [63:0] ra [2];
    logic [63:0] rb [2];
    logic [2:0]  aop [2];
    logic [5:0]  afn [2];
    logic [31:0] aa [2];
    logic [31:0] ab [2];
    logic [31:0] ares [2];
    logic        azero [2];
    logic [1:0]  rspv [2];
    logic [1:0]  rdy [2];
    logic [31:0] rres [2];
    logic        rzero [2];
    logic        bsy [2];

    int          tests = 0;
    int          fails = 0;
    exp_t        q0 [$];
    exp_t        q1 [$];
    exp_t        me;
    logic [72:0] prev [2];
    int          age [2] = '{0, 0};

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_alu_op(op[0]), .req_func(fn[0]), .req_a(ra[0]), .req_b(rb[0]),
        .alu_op(aop[0]), .alu_function(afn[0]), .alu_a(aa[0]), .alu_b(ab[0]),
        .alu_result(ares[0]), .alu_zero(azero[0]), .rsp_valid(rspv[0]), .rsp_ready(rdy[0]),
        .rsp_result(rres[0]), .rsp_zero(rzero[0]), .busy(bsy[0])
    );

    alu_share_arbiter #(.DATA_WIDTH(32), .LATENCY(3)) u_l3 (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_alu_op(op[1]), .req_func(fn[1]), .req_a(ra[1]), .req_b(rb[1]),
        .alu_op(aop[1]), .alu_function(afn[1]), .alu_a(aa[1]), .alu_b(ab[1]),
        .alu_result(ares[1]), .alu_zero(azero[1]), .rsp_valid(rspv[1]), .rsp_ready(rdy[1]),
        .rsp_result(rres[1]), .rsp_zero(rzero[1]), .busy(bsy[1])
    );

    // ALU model: result only becomes valid once inputs have been stable for LATENCY cycles
    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if ({aop[d], afn[d], aa[d], ab[d]} !== prev[d]) begin
                prev[d] = {aop[d], afn[d], aa[d], ab[d]};
                age[d] = 1;
            end else if (age[d] < 8)
                age[d] = age[d] + 1;

    assign ares[0]  = age[0] >= 1 ? (aop[0] == 3'b001 ? aa[0] - ab[0] : aa[0] + ab[0]) : 32'hDEADBEEF;
    assign ares[1]  = age[1] >= 3 ? (aop[1] == 3'b001 ? aa[1] - ab[1] : aa[1] + ab[1]) : 32'hDEADBEEF;
    assign azero[0] = ares[0] == 32'd0;
    assign azero[1] = ares[1] == 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input int d, input bit o, input logic [31:0] r);
        exp_t e;
        e.owner = o;
        e.res   = r;
        e.zero  = r == 32'd0;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk)
        for (int d = 0; d < 2; d++)
            if (|(rspv[d] & rdy[d])) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rsp_unexpected_dut%0d: got rsp_valid %b, required no response", d, rspv[d]);
                end else begin
                    if (d == 0) me = q0.pop_front();
                    else me = q1.pop_front();
                    chk($sformatf("rsp_owner_dut%0d", d), rspv[d], me.owner ? 2'b10 : 2'b01);
                    chk($sformatf("rsp_result_dut%0d", d), rres[d], me.res);
                    chk($sformatf("rsp_zero_dut%0d", d), rzero[d], me.zero);
                end
            end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rv[d] = 0; op[d] = 0; fn[d] = 0; ra[d] = 0; rb[d] = 0; rdy[d] = 0;
        end
        @(posedge clk);
        nxt();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_busy_dut%0d", d), bsy[d], 0);
            chk($sformatf("reset_rsp_valid_dut%0d", d), rspv[d], 0);
            chk($sformatf("reset_alu_a_dut%0d", d), aa[d], 0);
            chk($sformatf("reset_rsp_result_dut%0d", d), rres[d], 0);
        end
        reset = 0;
        nxt();
        // single ADD on the LATENCY=1 instance
        rv[0] = 2'b01; op[0] = 6'b000_111; fn[0] = 12'b000000_100000;
        ra[0] = 64'd5; rb[0] = 64'd7; rdy[0] = 2'b01;
        push(0, 0, 32'd12);
        #1 chk("add_req_ready", rr[0], 2'b01);
        chk("add_busy_c0", bsy[0], 0);
        nxt(); rv[0] = 0;
        #1 chk("add_busy_c1", bsy[0], 1);
        chk("add_rsp_valid_c1", rspv[0], 2'b00);
        chk("add_alu_a", aa[0], 5);
        chk("add_alu_op", aop[0], 3'b111);
        chk("add_alu_function", afn[0], 6'b100000);
        nxt();
        #1 chk("add_rsp_valid_c2", rspv[0], 2'b01);
        chk("add_busy_c2", bsy[0], 1);
        nxt();
        #1 chk("add_busy_c3", bsy[0], 0);
        // BEQ from requester 1
        rv[0] = 2'b10; op[0] = 6'b001_000; fn[0] = 0;
        ra[0] = {32'h1234, 32'h0}; rb[0] = {32'h1234, 32'h0}; rdy[0] = 2'b10;
        push(0, 1, 32'd0);
        #1 chk("beq_req_ready", rr[0], 2'b10);
        nxt(); rv[0] = 0;
        #1 chk("beq_alu_op", aop[0], 3'b001);
        chk("beq_alu_a", aa[0], 32'h1234);
        chk("beq_alu_b", ab[0], 32'h1234);
        nxt();
        #1 chk("beq_rsp_valid", rspv[0], 2'b10);
        nxt();
        // contention: both requesters valid continuously
        rv[0] = 2'b11; op[0] = 6'b111_111; fn[0] = {6'b100000, 6'b100000};
        ra[0] = {32'd10, 32'd1}; rb[0] = {32'd20, 32'd1}; rdy[0] = 2'b11;
        push(0, 0, 32'd2);
        push(0, !FIXED, FIXED ? 32'd2 : 32'd30);
        push(0, 0, 32'd2);
        for (int k = 0; k < 9; k++) begin
            #1 chk($sformatf("contend_ready_c%0d", k), rr[0],
                   k % 3 != 0 ? 2'b00 : (FIXED || (k / 3) % 2 == 0) ? 2'b01 : 2'b10);
            nxt();
        end
        rv[0] = 0;
        // response backpressure
        rv[0] = 2'b01; ra[0] = {32'd0, 32'd3}; rb[0] = {32'd0, 32'd4}; rdy[0] = 2'b00;
        push(0, 0, 32'd7);
        #1 chk("bp_req_ready_c0", rr[0], 2'b01);
        nxt(); rv[0] = 2'b11;
        #1 chk("bp_req_ready_exec", rr[0], 2'b00);
        nxt();
        for (int i = 0; i < 5; i++) begin
            rdy[0] = i < 3 ? 2'b00 : 2'b10;
            #1 chk($sformatf("bp_rsp_valid_%0d", i), rspv[0], 2'b01);
            chk($sformatf("bp_req_ready_%0d", i), rr[0], 2'b00);
            chk($sformatf("bp_rsp_result_%0d", i), rres[0], 32'd7);
            nxt();
        end
        rdy[0] = 2'b01; rv[0] = 0;
        #1 chk("bp_rsp_valid_release", rspv[0], 2'b01);
        nxt();
        #1 chk("bp_idle_busy", bsy[0], 0);
        chk("bp_idle_rsp_valid", rspv[0], 2'b00);
        // LATENCY=3 instance: ADDI wrapping to zero
        rv[1] = 2'b01; op[1] = 6'b000_100; fn[1] = 0;
        ra[1] = {32'd0, 32'hFFFF_FFFF}; rb[1] = 64'd1; rdy[1] = 2'b01;
        push(1, 0, 32'd0);
        #1 chk("l3_req_ready", rr[1], 2'b01);
        nxt(); rv[1] = 0;
        for (int c = 1; c <= 3; c++) begin
            #1 chk($sformatf("l3_alu_op_c%0d", c), aop[1], 3'b100);
            chk($sformatf("l3_alu_a_c%0d", c), aa[1], 32'hFFFF_FFFF);
            chk($sformatf("l3_alu_b_c%0d", c), ab[1], 32'd1);
            chk($sformatf("l3_rsp_valid_c%0d", c), rspv[1], 2'b00);
            nxt();
        end
        #1 chk("l3_rsp_valid_c4", rspv[1], 2'b01);
        nxt();
        #1 chk("l3_busy_c5", bsy[1], 0);
        // reset in the middle of EXEC drops the operation
        rv[0] = 2'b01; ra[0] = {32'd0, 32'd8}; rb[0] = {32'd0, 32'd9}; rdy[0] = 2'b01;
        nxt(); rv[0] = 0;
        #2 reset = 1;
        #1 chk("rst_busy", bsy[0], 0);
        chk("rst_rsp_valid", rspv[0], 2'b00);
        chk("rst_req_ready", rr[0], 2'b00);
        chk("rst_alu_op", aop[0], 0);
        chk("rst_alu_function", afn[0], 0);
        chk("rst_alu_a", aa[0], 0);
        chk("rst_alu_b", ab[0], 0);
        chk("rst_rsp_result", rres[0], 0);
        chk("rst_rsp_zero", rzero[0], 0);
        nxt();
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            nxt();
            #1 chk($sformatf("rst_no_rsp_%0d", i), rspv[0], 2'b00);
        end
        rv[0] = 2'b01; ra[0] = {32'd0, 32'd2}; rb[0] = {32'd0, 32'd2};
        push(0, 0, 32'd4);
        #1 chk("rst_regrant", rr[0], 2'b01);
        nxt(); rv[0] = 0;
        nxt();
        nxt();
        repeat (3) nxt();
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
